// File: rtl/bit_sequencer_pkg.sv
// Shared types and width helpers for the bit_sequencer block.
package bit_sequencer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Bits needed to encode n distinct values, never less than one.
    function automatic int width_for(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lowest_one_finder.sv
// Combinational priority encoder: index of the lowest set bit plus an any-set flag.
module lowest_one_finder
    import bit_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = width_for(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] vec,
    output logic [IDX_WIDTH-1:0]  idx,
    output logic                  any
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        idx = '0;
        any = |vec;
        // Scanning downwards lets the lowest set bit win the last assignment.
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_WIDTH'(i);
        end
    end

endmodule

// File: rtl/bit_sequencer.sv
// Expands a multi-hot mask into a stream of set-bit indices, lowest first.
// Optional remain_o output is enabled by defining BIT_SEQUENCER_REMAIN_EN.
module bit_sequencer
    import bit_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = width_for(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  a_rst,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] mask_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [IDX_WIDTH-1:0]  idx_o,
    output logic                  last_o,
    output logic                  valid_o,
    input  logic                  ready_i
`ifdef BIT_SEQUENCER_REMAIN_EN
    ,
    output logic [width_for(DATA_WIDTH+1)-1:0] remain_o
`endif
);

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] pend, pend_n;
    logic [IDX_WIDTH-1:0]  low_idx;
    logic                  pend_any;
    logic                  busy;
    logic                  single;
    logic                  beat;
    logic                  accept;

    lowest_one_finder #(
        .DATA_WIDTH(DATA_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_finder (
        .vec(pend),
        .idx(low_idx),
        .any(pend_any)
    );

    assign busy    = (state == BUSY);
    assign single  = ((pend & (pend - ONE)) == '0);
    assign valid_o = busy;
    assign idx_o   = busy ? low_idx : '0;
    assign last_o  = busy && pend_any && single;
    assign beat    = valid_o && ready_i;
    assign ready_o = !busy || (beat && last_o);
    assign accept  = valid_i && ready_o && !flush_i;

    always_ff @(posedge clk or posedge a_rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (a_rst) begin
            state <= IDLE;
            pend  <= '0;
        end else begin
            state <= state_n;
            pend  <= pend_n;
        end
    end

    always_comb begin
        state_n = state;
        pend_n  = pend;
        if (flush_i) begin
            state_n = IDLE;
            pend_n  = '0;
        end else begin
            if (beat) begin
                pend_n = pend & (pend - ONE);
                if (last_o) state_n = IDLE;
            end
            // An accept on the final beat overrides the drained pend.
            if (accept) begin
                pend_n  = mask_i;
                state_n = (mask_i != '0) ? BUSY : IDLE;
            end
        end
    end

`ifdef BIT_SEQUENCER_REMAIN_EN
    localparam int RW = width_for(DATA_WIDTH + 1);

    logic [RW-1:0] remain_q;

    function automatic logic [RW-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
        logic [RW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DATA_WIDTH; i++) cnt = cnt + RW'(v[i]);
        return cnt;
    endfunction

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            remain_q <= '0;
        end else if (flush_i) begin
            remain_q <= '0;
        end else if (accept) begin
            remain_q <= (mask_i != '0) ? popcount(mask_i) - RW'(1) : '0;
        end else if (beat && !last_o) begin
            remain_q <= remain_q - RW'(1);
        end
    end

    assign remain_o = valid_o ? remain_q : '0;
`endif

endmodule
